ifu: RTL and testbench
======================

# ifu

Instruction fetch unit: holds the PC, issues one word-aligned fetch at a time to instruction memory over a valid/ready request and a valid-only response, and buffers returned instructions in a small queue. Each queued instruction is presented with its PC to the decode stage under a valid/ready handshake. It sits directly upstream of the ID-stage decoder and accepts PC redirects from branch/jump resolution downstream.

## Interface
- `RESET_PC`, 64'h8000_0000, PC fetched first after reset.
- `XLEN`, 64, PC/address width.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  XLEN  fetch address, always [1:0]=0.
- `imem_resp_valid`  in  1  response data valid, one pulse per accepted request.
- `imem_resp_data`  in  32  fetched instruction.
- `redirect_valid`  in  1  flush and restart fetch.
- `redirect_pc`  in  XLEN  new fetch PC; bits [1:0] ignored (forced 0).
- `id_valid`  out  1  instruction available to decode.
- `id_ready`  in  1  decode accepts instruction.
- `id_inst`  out  32  instruction at queue head.
- `id_pc`  out  XLEN  PC of `id_inst`.

## Operation
- State machine, 3 states: REQ (no request outstanding), WAIT (one outstanding, response kept), DROP (one outstanding, response discarded).
- REQ: `imem_req_valid` = (queue count < DEPTH); `imem_req_addr` = pc register. On request handshake: pc += 4, tag PC latched, go WAIT.
- WAIT: on `imem_resp_valid` push {data, tag PC} into queue, go REQ. Space is guaranteed because requests issue only with a free slot.
- DROP: on `imem_resp_valid` discard data, go REQ.
- Dequeue on `id_valid & id_ready`; `id_inst`/`id_pc` = queue head; `id_valid` = queue non-empty.
- Redirect (highest priority, applied at the clock edge): pc <= {redirect_pc[XLEN-1:2],2'b0}; queue cleared. The next state is DROP if a request is outstanding after this edge, otherwise REQ. A request is outstanding after the edge if the state is WAIT without a response this cycle, or REQ with a request handshake this cycle.
- Redirect in WAIT with `imem_resp_valid` the same cycle: response discarded, go REQ.
- Redirect with a same-cycle ID handshake: the handshake completes and the entry counts as consumed. Squashing it is downstream's job.
- Redirect while in DROP: stay DROP, pc updated.
- PC arithmetic is modulo 2^XLEN; 0xFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- Pushing and popping in the same cycle leaves the count unchanged. Queue pointers wrap modulo DEPTH.

## Timing
- Reset values: pc=RESET_PC, state=REQ, queue empty, `imem_req_valid`=0 while `rst` high, `id_valid`=0, `id_inst`=0, `id_pc`=0 when empty.
- Request accepted cycle N, response earliest N+1, `id_valid` earliest N+2. No bypass from response to `id_*`.
- Response in cycle M allows the next request in M+1. Peak throughput is 1 instruction per 2 cycles with 1-cycle memory.
- `imem_req_valid` is held with a stable address until ready, except when a redirect changes the address.
- Reset asserted mid-operation returns everything to reset values immediately. A response arriving after reset deassertion with no outstanding request is ignored.

## Configuration
- `IFU_QUEUE2_EN` defined: DEPTH=2. Fetch continues while one instruction waits at decode.
- Undefined: DEPTH=1. A new request issues only when the queue is empty, or is being popped in the same cycle the REQ state is evaluated.

## Structure
- Shared package/defines: `RESET_PC` default, `InstWidth`=32, FSM state encodings (IFU_REQ/IFU_WAIT/IFU_DROP), DEPTH selection from `IFU_QUEUE2_EN`.
- Sub-module `ifu_queue`: synchronous FIFO of {pc, inst} entries with push/pop/flush/count and asynchronous reset. Its depth is a parameter.

## Test plan
- Reset release, memory always ready, 1-cycle response: requests to 0x8000_0000, 0x8000_0004, 0x8000_0008, …; ID sees those PCs in order, first `id_valid` 2 cycles after the first handshake.
- `id_ready`=0 held: with `IFU_QUEUE2_EN`, exactly 2 requests issue and then `imem_req_valid`=0. Without it, exactly 1 request issues. Raising `id_ready` resumes fetch.
- Redirect to 0x8000_0103 while in WAIT: the stale response is dropped, the next request address is 0x8000_0100, and `id_valid` stays 0 until that instruction returns.
- Redirect in the same cycle as a response: no enqueue, next request to redirect_pc the following cycle.
- `imem_req_ready` low for 5 cycles: address stable, pc not incremented. A redirect during the stall changes the address the next cycle.
- pc=0xFFFF_FFFF_FFFF_FFFC fetched: the next request address is 0x0. Asserting `rst` mid-WAIT: `id_valid`=0 and next request to RESET_PC.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared constants, FSM encodings and queue sizing for the IFU.
// IFU_QUEUE2_EN selects a 2-entry instruction queue (default 1 entry).
package ifu_pkg;

   localparam int IFU_XLEN = 64;
   localparam logic [IFU_XLEN-1:0] IFU_RESET_PC = 64'h8000_0000;
   localparam int InstWidth = 32;

`ifdef IFU_QUEUE2_EN
   localparam int IFU_DEPTH = 2;
`else
   localparam int IFU_DEPTH = 1;
`endif

   localparam int CountW = $clog2(IFU_DEPTH + 1);

   typedef enum logic [1:0] {
      IFU_REQ  = 2'd0,
      IFU_WAIT = 2'd1,
      IFU_DROP = 2'd2
   } ifu_state_e;

endpackage

// File: rtl/ifu_queue.sv
// ifu_queue: small synchronous FIFO of {pc, inst} entries.
// Flush wins over push/pop; head reads as zero while empty.
module ifu_queue #(
   parameter int DEPTH = 1,
   parameter int W     = 96,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [CW-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) return '0;
      return p + 1'b1;
   endfunction

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
   assign rdata   = (count != '0) ? mem[rd_ptr] : '0;

   // pointers, occupancy and storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= nxt(wr_ptr);
         end
         if (do_pop) rd_ptr <= nxt(rd_ptr);
         if (do_push && !do_pop) count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/ifu.sv
// ifu: PC, single-outstanding imem fetch and decode-side queue.
// IFU_QUEUE2_EN keeps fetching while one instruction waits at decode.
module ifu
   import ifu_pkg::*;
#(
   parameter int XLEN = IFU_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 imem_req_valid,
   input  logic                 imem_req_ready,
   output logic [XLEN-1:0]      imem_req_addr,
   input  logic                 imem_resp_valid,
   input  logic [InstWidth-1:0] imem_resp_data,
   input  logic                 redirect_valid,
   input  logic [XLEN-1:0]      redirect_pc,
   output logic                 id_valid,
   input  logic                 id_ready,
   output logic [InstWidth-1:0] id_inst,
   output logic [XLEN-1:0]      id_pc
);

   localparam int EW = XLEN + InstWidth;

   ifu_state_e        state;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   tag_pc;
   logic [CountW-1:0] q_count;
   logic [EW-1:0]     q_head;
   logic              slot_free;
   logic              req_fire;
   logic              id_fire;
   logic              push;
   logic              unused_pc_lo;

   assign unused_pc_lo = ^redirect_pc[1:0];

`ifdef IFU_QUEUE2_EN
   assign slot_free = (q_count < CountW'(IFU_DEPTH));
`else
   assign slot_free = (q_count == '0) || id_fire;
`endif

   assign id_valid       = (q_count != '0);
   assign id_fire        = id_valid && id_ready;
   assign imem_req_valid = !rst && (state == IFU_REQ) && slot_free;
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign push           = (state == IFU_WAIT) && imem_resp_valid
                           && !redirect_valid;
   assign id_inst        = q_head[InstWidth-1:0];
   assign id_pc          = q_head[EW-1:InstWidth];

   // pc, request tag and fetch state machine
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IFU_REQ;
         pc     <= RESET_PC;
         tag_pc <= '0;
      end else begin
         if (req_fire) tag_pc <= pc;
         if (redirect_valid)
            pc <= {redirect_pc[XLEN-1:2], 2'b00};
         else if (req_fire)
            pc <= pc + XLEN'(4);
         unique case (state)
            IFU_REQ: begin
               if (req_fire)
                  state <= redirect_valid ? IFU_DROP : IFU_WAIT;
            end
            IFU_WAIT: begin
               if (imem_resp_valid) state <= IFU_REQ;
               else if (redirect_valid) state <= IFU_DROP;
            end
            IFU_DROP: begin
               if (imem_resp_valid) state <= IFU_REQ;
            end
            default: state <= IFU_REQ;
         endcase
      end
   end

   ifu_queue #(
      .DEPTH (IFU_DEPTH),
      .W     (EW),
      .CW    (CountW)
   ) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (id_fire),
      .flush (redirect_valid),
      .wdata ({tag_pc, imem_resp_data}),
      .rdata (q_head),
      .count (q_count)
   );

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed checks of the fetch unit against a small imem model.
// Works for both queue depths (IFU_QUEUE2_EN defined or not).
module tb_ifu;
   import ifu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_inst;
   logic [63:0] id_pc;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lat = 1;

   logic [63:0] req_q[$];
   int          req_cyc[$];
   logic [63:0] id_pc_q[$];
   logic [31:0] id_inst_q[$];
   int          id_cyc[$];

   logic        pend = 1'b0;
   int          pcnt = 0;
   logic [63:0] paddr = '0;

   ifu dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .id_valid        (id_valid),
      .id_ready        (id_ready),
      .id_inst         (id_inst),
      .id_pc           (id_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
   endfunction

   // imem model: one response per accepted request after lat cycles
   always @(posedge clk) begin
      imem_resp_valid <= 1'b0;
      if (rst) begin
         pend <= 1'b0;
      end else begin
         if (pend) begin
            if (pcnt == 1) begin
               imem_resp_valid <= 1'b1;
               imem_resp_data  <= inst_of(paddr);
               pend            <= 1'b0;
            end else begin
               pcnt <= pcnt - 1;
            end
         end
         if (imem_req_valid && imem_req_ready) begin
            if (lat == 1) begin
               imem_resp_valid <= 1'b1;
               imem_resp_data  <= inst_of(imem_req_addr);
            end else begin
               pend  <= 1'b1;
               pcnt  <= lat - 1;
               paddr <= imem_req_addr;
            end
         end
      end
   end

   // record request and decode handshakes
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && imem_req_valid && imem_req_ready) begin
         req_q.push_back(imem_req_addr);
         req_cyc.push_back(cyc);
      end
      if (!rst && id_valid && id_ready) begin
         id_pc_q.push_back(id_pc);
         id_inst_q.push_back(id_inst);
         id_cyc.push_back(cyc);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_fire(input string nm);
      int n0;
      int k;
      n0 = req_q.size();
      k = 0;
      while (req_q.size() == n0 && k < 100) begin
         step(1);
         k++;
      end
      checks++;
      if (req_q.size() == n0) begin
         errors++;
         $display("FAIL %s: requests seen %0d, required > %0d", nm,
                  req_q.size(), n0);
      end
   endtask

   task automatic redirect(input logic [63:0] a);
      redirect_valid = 1'b1;
      redirect_pc    = a;
      step(1);
      redirect_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      id_ready = 1'b1;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      lat = 1;
      step(3);
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_req_valid: got %b need 0", imem_req_valid);
      end
      checks++;
      if (id_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_id_valid: got %b need 0", id_valid);
      end
      checks++;
      if (id_inst !== 32'h0 || id_pc !== 64'h0) begin
         errors++;
         $display("FAIL rst_id_data: got %h/%h need 0/0", id_inst, id_pc);
      end
      step(1);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== IFU_RESET_PC) begin
         errors++;
         $display("FAIL rst_first_req: got %b/%h need 1/%h",
                  imem_req_valid, imem_req_addr, IFU_RESET_PC);
      end
   endtask

   task automatic test_stream;
      logic [63:0] e;
      step(20);
      checks++;
      if (req_q.size() < 4 || id_pc_q.size() < 4) begin
         errors++;
         $display("FAIL stream_count: got %0d/%0d need >=4/>=4",
                  req_q.size(), id_pc_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            e = IFU_RESET_PC + 64'(4 * i);
            checks++;
            if (req_q[i] !== e) begin
               errors++;
               $display("FAIL stream_req%0d: got %h need %h", i, req_q[i], e);
            end
            checks++;
            if (id_pc_q[i] !== e || id_inst_q[i] !== inst_of(e)) begin
               errors++;
               $display("FAIL stream_id%0d: got %h/%h need %h/%h", i,
                        id_pc_q[i], id_inst_q[i], e, inst_of(e));
            end
         end
         checks++;
         if (id_cyc[0] - req_cyc[0] !== 2) begin
            errors++;
            $display("FAIL stream_latency: got %0d need 2",
                     id_cyc[0] - req_cyc[0]);
         end
         checks++;
         if (req_cyc[1] - req_cyc[0] !== 2) begin
            errors++;
            $display("FAIL stream_rate: got %0d need 2",
                     req_cyc[1] - req_cyc[0]);
         end
      end
   endtask

   task automatic test_backpressure;
      int r0;
      int d0;
      logic [63:0] e;
      id_ready = 1'b0;
      redirect(64'h9000_0000);
      r0 = req_q.size();
      d0 = id_pc_q.size();
      step(20);
      @(negedge clk);
      checks++;
      if (req_q.size() - r0 !== IFU_DEPTH) begin
         errors++;
         $display("FAIL bp_req_count: got %0d need %0d",
                  req_q.size() - r0, IFU_DEPTH);
      end
      checks++;
      if (imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_req_valid: got %b need 0", imem_req_valid);
      end
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 64'h9000_0000
          || id_inst !== inst_of(64'h9000_0000)) begin
         errors++;
         $display("FAIL bp_head: got %b/%h/%h need 1/%h/%h", id_valid, id_pc,
                  id_inst, 64'h9000_0000, inst_of(64'h9000_0000));
      end
      step(1);
      id_ready = 1'b1;
      step(20);
      checks++;
      if (id_pc_q.size() - d0 < 4) begin
         errors++;
         $display("FAIL bp_resume: got %0d pops need >=4",
                  id_pc_q.size() - d0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            e = 64'h9000_0000 + 64'(4 * i);
            checks++;
            if (id_pc_q[d0 + i] !== e) begin
               errors++;
               $display("FAIL bp_pc%0d: got %h need %h", i,
                        id_pc_q[d0 + i], e);
            end
         end
      end
   endtask

   task automatic test_redirect_wait;
      int r0;
      int d0;
      int k;
      bit bad;
      lat = 4;
      wait_fire("rdw_fire");
      lat = 1;
      redirect(64'h8000_0103);
      r0 = req_q.size();
      d0 = id_pc_q.size();
      bad = 1'b0;
      k = 0;
      while (req_q.size() == r0 && k < 50) begin
         @(negedge clk);
         if (id_valid) bad = 1'b1;
         step(1);
         k++;
      end
      @(negedge clk);
      if (id_valid) bad = 1'b1;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL rdw_idle: id_valid got 1 need 0 before refetch");
      end
      checks++;
      if (req_q.size() == r0 || req_q[r0] !== 64'h8000_0100) begin
         errors++;
         $display("FAIL rdw_addr: got %h need %h",
                  (req_q.size() > r0) ? req_q[r0] : 64'hx, 64'h8000_0100);
      end
      step(6);
      checks++;
      if (id_pc_q.size() == d0 || id_pc_q[d0] !== 64'h8000_0100) begin
         errors++;
         $display("FAIL rdw_id: got %h need %h",
                  (id_pc_q.size() > d0) ? id_pc_q[d0] : 64'hx, 64'h8000_0100);
      end
   endtask

   task automatic test_redirect_resp;
      int r0;
      int d0;
      lat = 1;
      wait_fire("rdr_fire");
      redirect(64'h8000_2000);
      r0 = req_q.size();
      d0 = id_pc_q.size();
      @(negedge clk);
      checks++;
      if (id_valid !== 1'b0) begin
         errors++;
         $display("FAIL rdr_noenq: id_valid got %b need 0", id_valid);
      end
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_2000) begin
         errors++;
         $display("FAIL rdr_req: got %b/%h need 1/%h", imem_req_valid,
                  imem_req_addr, 64'h8000_2000);
      end
      step(6);
      checks++;
      if (id_pc_q.size() == d0 || id_pc_q[d0] !== 64'h8000_2000) begin
         errors++;
         $display("FAIL rdr_id: got %h need %h",
                  (id_pc_q.size() > d0) ? id_pc_q[d0] : 64'hx, 64'h8000_2000);
      end
   endtask

   task automatic test_stall;
      int r0;
      int d0;
      imem_req_ready = 1'b0;
      redirect(64'h8000_3000);
      step(3);
      r0 = req_q.size();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_3000) begin
            errors++;
            $display("FAIL stall_hold%0d: got %b/%h need 1/%h", i,
                     imem_req_valid, imem_req_addr, 64'h8000_3000);
         end
         step(1);
      end
      redirect(64'h8000_400B);
      d0 = id_pc_q.size();
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_4008) begin
         errors++;
         $display("FAIL stall_redir: got %b/%h need 1/%h", imem_req_valid,
                  imem_req_addr, 64'h8000_4008);
      end
      checks++;
      if (req_q.size() !== r0) begin
         errors++;
         $display("FAIL stall_nofire: got %0d fires need 0",
                  req_q.size() - r0);
      end
      step(1);
      imem_req_ready = 1'b1;
      step(6);
      checks++;
      if (id_pc_q.size() == d0 || id_pc_q[d0] !== 64'h8000_4008) begin
         errors++;
         $display("FAIL stall_id: got %h need %h",
                  (id_pc_q.size() > d0) ? id_pc_q[d0] : 64'hx, 64'h8000_4008);
      end
   endtask

   task automatic test_wrap;
      int r0;
      int d0;
      redirect(64'hFFFF_FFFF_FFFF_FFFC);
      r0 = req_q.size();
      d0 = id_pc_q.size();
      step(12);
      checks++;
      if (req_q.size() < r0 + 2 || req_q[r0] !== 64'hFFFF_FFFF_FFFF_FFFC
          || req_q[r0 + 1] !== 64'h0) begin
         errors++;
         $display("FAIL wrap_req: got %0d reqs, need FFFFFFFFFFFFFFFC then 0",
                  req_q.size() - r0);
      end
      checks++;
      if (id_pc_q.size() < d0 + 2 || id_pc_q[d0 + 1] !== 64'h0
          || id_inst_q[d0 + 1] !== inst_of(64'h0)) begin
         errors++;
         $display("FAIL wrap_id: got %0d pops, need pc 0 second",
                  id_pc_q.size() - d0);
      end
   endtask

   task automatic test_reset_mid;
      int d0;
      lat = 3;
      wait_fire("rst_mid_fire");
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (id_valid !== 1'b0 || imem_req_valid !== 1'b0 || id_pc !== 64'h0) begin
         errors++;
         $display("FAIL rst_mid: got %b/%b/%h need 0/0/0", id_valid,
                  imem_req_valid, id_pc);
      end
      step(1);
      rst = 1'b0;
      lat = 1;
      d0 = id_pc_q.size();
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== IFU_RESET_PC) begin
         errors++;
         $display("FAIL rst_mid_req: got %b/%h need 1/%h", imem_req_valid,
                  imem_req_addr, IFU_RESET_PC);
      end
      step(6);
      checks++;
      if (id_pc_q.size() == d0 || id_pc_q[d0] !== IFU_RESET_PC) begin
         errors++;
         $display("FAIL rst_mid_id: got %h need %h",
                  (id_pc_q.size() > d0) ? id_pc_q[d0] : 64'hx, IFU_RESET_PC);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_wait();
      test_redirect_resp();
      test_stall();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
